// File: rtl/mac_accumulator.sv
// Block multiply-accumulate stage: sums a programmable number of signed products
// with saturation, then holds the result until downstream accepts it.
module mac_accumulator #(
  parameter int PW = 24,
  parameter int AW = 28,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prod_valid,
  input  logic [PW-1:0] prod_data,
  output logic          prod_ready,
  input  logic [LW-1:0] len,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_data,
  output logic          out_sat,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

  state_t        state, state_nxt;
  logic [AW-1:0] acc, acc_nxt;
  logic [LW-1:0] cnt, cnt_nxt;
  logic [LW-1:0] len_q, len_nxt;
  logic          sat, sat_nxt;

  logic          in_xfer;
  logic          out_xfer;
  logic [AW-1:0] prod_ext;
  logic [AW:0]   sum;
  logic          sum_ovf;
  logic [AW-1:0] sum_sat;
  logic [LW-1:0] cnt_inc;

  assign in_xfer  = prod_valid & prod_ready;
  assign out_xfer = out_valid & out_ready;
  assign prod_ext = {{(AW-PW){prod_data[PW-1]}}, prod_data};
  assign cnt_inc  = cnt + LW'(1);

  // One guard bit: the top two sum bits disagree exactly when the true result
  // falls outside the AW-bit signed range, and the guard bit gives its sign.
  assign sum     = {acc[AW-1], acc} + {prod_ext[AW-1], prod_ext};
  assign sum_ovf = sum[AW] ^ sum[AW-1];
  assign sum_sat = !sum_ovf ? sum[AW-1:0] : (sum[AW] ? ACC_MIN : ACC_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      len_q <= len_nxt;
      sat   <= sat_nxt;
    end
  end

  // len of 0 or 1 both mean a single-product block and go straight to HOLD.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    len_nxt   = len_q;
    sat_nxt   = sat;
    case (state)
      IDLE: begin
        if (in_xfer) begin
          acc_nxt   = prod_ext;
          cnt_nxt   = LW'(1);
          sat_nxt   = 1'b0;
          len_nxt   = len;
          state_nxt = (len <= LW'(1)) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (in_xfer) begin
          acc_nxt = sum_sat;
          sat_nxt = sat | sum_ovf;
          cnt_nxt = cnt_inc;
          if (cnt_inc == len_q) state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_xfer) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign prod_ready = (state != HOLD);
  assign out_valid  = (state == HOLD);
  assign busy       = (state != IDLE);
  assign out_data   = acc;
  assign out_sat    = sat;

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: driver pushes expected block results,
// monitor pops and compares them while the DUT holds its result.
module tb_mac_accumulator;

  localparam int PW = 24;
  localparam int AW = 28;
  localparam int LW = 8;

  typedef struct {
    longint data;
    bit     sat;
    int     stall;
    int     expCycle;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          prod_valid;
  logic [PW-1:0] prod_data;
  logic          prod_ready;
  logic [LW-1:0] len;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic          out_sat;
  logic          busy;

  int     total;
  int     bad;
  int     cycleCnt;
  exp_t   sb[$];
  int     stim[$];
  bit     inHold;
  int     holdCnt;

  mac_accumulator #(.PW(PW), .AW(AW), .LW(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .prod_valid(prod_valid),
    .prod_data (prod_data),
    .prod_ready(prod_ready),
    .len       (len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", tag, actual, expected, cycleCnt);
    end
  endtask

  task automatic waitReady();
    int budget;
    budget = 200;
    while (!prod_ready && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (budget == 0) checkOutput("ready_timeout", 0, 1);
  endtask

  // Drives one block from stim[], models the saturating sum, and pushes the
  // expected result once the final product has been accepted.
  task automatic applyStimulus(input int blkLen, input int gap, input int stall, input bit junkInHold);
    int     n;
    longint acc;
    bit     s;
    longint lim;
    lim = (64'sd1 <<< (AW-1));
    n = (blkLen == 0) ? 1 : blkLen;
    acc = 0;
    s = 1'b0;
    for (int i = 0; i < n; i++) begin
      waitReady();
      prod_valid = 1'b1;
      prod_data  = PW'(stim[i]);
      len        = (i == 0) ? LW'(blkLen) : LW'($urandom);
      if (i == 0) acc = stim[i];
      else begin
        acc = acc + stim[i];
        if (acc > lim - 1) begin acc = lim - 1; s = 1'b1; end
        if (acc < -lim)    begin acc = -lim;    s = 1'b1; end
      end
      @(posedge clk); #1;
      prod_valid = 1'b0;
      prod_data  = PW'($urandom);
      len        = LW'($urandom);
      if (i == n - 1) sb.push_back('{acc, s, stall, cycleCnt});
      else begin
        checkOutput("busy_accum", busy, 1);
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
    if (junkInHold) begin
      prod_valid = 1'b1;
      prod_data  = PW'(999);
      repeat (3) begin
        checkOutput("ready_in_hold", prod_ready, 0);
        @(posedge clk); #1;
      end
      prod_valid = 1'b0;
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valid"}, out_valid, 0);
    checkOutput({tag, "_data"}, out_data, 0);
    checkOutput({tag, "_sat"}, out_sat, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_ready"}, prod_ready, 1);
  endtask

  // Monitor: sample mid-cycle, compare every HOLD cycle against the head of the
  // scoreboard, and release out_ready once the requested stall has elapsed.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_out", 1, 0);
        out_ready = 1'b1;
      end else begin
        if (!inHold) begin
          checkOutput("latency", cycleCnt, sb[0].expCycle);
          inHold  = 1'b1;
          holdCnt = 0;
        end
        checkOutput("out_data", longint'($signed(out_data)), sb[0].data);
        checkOutput("out_sat", out_sat, sb[0].sat);
        checkOutput("hold_ready", prod_ready, 0);
        checkOutput("hold_busy", busy, 1);
        if (holdCnt >= sb[0].stall) begin
          out_ready = 1'b1;
          void'(sb.pop_front());
          inHold = 1'b0;
        end else begin
          out_ready = 1'b0;
        end
        holdCnt++;
      end
    end else begin
      out_ready = 1'b1;
      if (!rst_n) inHold = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int budget;
    total = 0; bad = 0; cycleCnt = 0;
    inHold = 1'b0; holdCnt = 0;
    rst_n = 1'b0; prod_valid = 1'b0; prod_data = '0; len = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    stim = '{100, -30, 7, 1};
    applyStimulus(4, 0, 0, 1'b0);

    stim = '{5, 5, 5};
    applyStimulus(3, 2, 5, 1'b1);

    stim.delete();
    for (int i = 0; i < 32; i++) stim.push_back(8388607);
    applyStimulus(32, 0, 1, 1'b0);

    stim.delete();
    for (int i = 0; i < 32; i++) stim.push_back(-8388608);
    stim.push_back(1000);
    applyStimulus(33, 0, 0, 1'b0);

    stim = '{-5};
    applyStimulus(0, 0, 0, 1'b0);
    applyStimulus(1, 0, 2, 1'b0);

    stim.delete();
    for (int i = 0; i < 6; i++) stim.push_back(int'($urandom_range(0, 16777215)) - 8388608);
    applyStimulus(6, 1, 1, 1'b0);

    // Abort a len=8 block after three accepts; the product offered during reset is dropped.
    waitReady();
    len = LW'(8);
    for (int i = 0; i < 3; i++) begin
      prod_valid = 1'b1;
      prod_data  = PW'(10);
      @(posedge clk); #1;
    end
    checkOutput("busy_before_abort", busy, 1);
    rst_n = 1'b0;
    prod_data = PW'(55);
    @(posedge clk); #1;
    rst_n = 1'b1;
    prod_valid = 1'b0;
    checkResetOutputs("abort");
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("idle_after_abort", busy, 0);

    stim = '{1, 2};
    applyStimulus(2, 0, 0, 1'b0);

    budget = 500;
    while (sb.size() != 0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (budget == 0) checkOutput("drain_timeout", sb.size(), 0);
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("final_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 Parameter PW, default 24, width of the signed product input (matches the 16x8 signed array multiplier output Z).
REQ-002 Parameter AW, default 28, width of the signed accumulator and result.
REQ-003 Parameter LW, default 8, width of the block-length input.
REQ-004 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1, reset, synchronous and active-low.
REQ-006 Port prod_valid, input, 1, product word valid.
REQ-007 Port prod_data, input, PW, two's-complement product from the multiplier.
REQ-008 Port prod_ready, output, 1, block can accept a product this cycle.
REQ-009 Port len, input, LW, number of products per block; sampled only on the first accept of a block.
REQ-010 Port out_valid, output, 1, result valid.
REQ-011 Port out_ready, input, 1, downstream accepts result.
REQ-012 Port out_data, output, AW, signed accumulated result.
REQ-013 Port out_sat, output, 1, saturation occurred at any point in this block.
REQ-014 Port busy, output, 1, high in ACCUM or HOLD.

Function
REQ-015 An input transfer occurs in any cycle with prod_valid=1 and prod_ready=1; an output transfer occurs in any cycle with out_valid=1 and out_ready=1.
REQ-016 The FSM has three states:
- IDLE: prod_ready=1, out_valid=0.
- ACCUM: prod_ready=1, out_valid=0.
- HOLD: prod_ready=0, out_valid=1.
REQ-017 IDLE, on input transfer:
- acc <= sign-extended prod_data; cnt <= 1; sat <= 0; len_q <= len.
- Effective length 1 (len of 0 or 1) -> HOLD; otherwise -> ACCUM.
REQ-018 ACCUM, on input transfer:
- acc <= sat(acc + sext(prod_data)); cnt <= cnt+1.
- If cnt+1 equals len_q -> HOLD.
REQ-019 len=0 is treated as length 1.
REQ-020 ACCUM with no input transfer holds all state; gaps in prod_valid of any length are permitted.
REQ-021 HOLD: out_data and out_sat come directly from registers and are stable while out_valid=1 and out_ready=0.
REQ-022 HOLD, on output transfer -> IDLE. No product is accepted in that cycle (prod_ready=0 throughout HOLD).
REQ-023 Latency: out_valid rises the cycle after the input transfer of the final product of the block.
REQ-024 Addition is performed at AW+1 bits:
- Result above 2^(AW-1)-1 -> acc clamps to 0x7FFFFFF (AW=28).
- Result below -2^(AW-1) -> acc clamps to 0x8000000 (AW=28).
- Either clamp sets sat=1, which stays set until the next block starts.
REQ-025 Saturation is evaluated per addition, so later terms may move the accumulator off the clamp value; out_sat remains 1.
REQ-026 out_data = acc and out_sat = sat at all times; their values outside HOLD are don't-care for consumers.
REQ-027 A change to len during ACCUM or HOLD has no effect on the current block.
REQ-028 busy = (state != IDLE).

Reset
REQ-029 On a clk edge with rst_n=0: state <= IDLE, acc <= 0, cnt <= 0, len_q <= 0, sat <= 0.
REQ-030 Reset values seen at the outputs: out_valid=0, out_data=0, out_sat=0, busy=0, prod_ready=1 (IDLE).
REQ-031 Reset asserted mid-block (ACCUM or HOLD) discards the partial block; no result is ever emitted for it.
REQ-032 An input transfer in the same cycle as rst_n=0 is ignored.

Verification
REQ-033 len=4, products 100, -30, 7, 1 with continuous valid and out_ready=1 -> one cycle after the 4th accept: out_valid=1, out_data=78, out_sat=0; next cycle IDLE.
REQ-034 len=3, products 5, 5, 5 with prod_valid gapped by 2 idle cycles between words, and out_ready held 0 for 5 cycles -> out_data=15 stable for all stall cycles, prod_ready=0 throughout HOLD, prod_valid ignored during HOLD.
REQ-035 len=32, every product 0x7FFFFF (8388607) -> out_data=0x7FFFFFF, out_sat=1.
REQ-036 len=33, first 32 products 0x800000 (-8388608) followed by +1000 -> clamp at 0x8000000 reached, final out_data=-134216728, out_sat=1.
REQ-037 len=0 then len=1, single product -5 each -> each block gives out_data=-5 one cycle after accept.
REQ-038 len=8, rst_n driven 0 after 3 accepts, then a new block len=2 with products 1, 2 -> no result from the aborted block; then out_data=3, out_sat=0.
